// File: rtl/sdram_responder.sv
// sdram_responder: fixed-latency single-byte SDRAM responder with a 2^ADDR_W byte backing store.
// Ports: clk/rst (sync, active-high); sdram_addr/sdram_din/sdram_wr_rd/sdram_mstrb request in;
//        sdram_dout read data, sdram_ack completion pulse, sdram_busy in progress, sdram_ovr sticky overrun.
module sdram_responder #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] sdram_addr,
   input  logic [DATA_W-1:0] sdram_din,
   input  logic              sdram_wr_rd,
   input  logic              sdram_mstrb,
   output logic [DATA_W-1:0] sdram_dout,
   output logic              sdram_ack,
   output logic              sdram_busy,
   output logic              sdram_ovr
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d, dout_q, dout_d;
   logic              wr_q, wr_d, ack_q, ack_d, busy_q, busy_d, ovr_q, ovr_d;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic              done;
   assign done = state_q == WAIT && cnt_q == 4'd0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      wr_d    = wr_q;
      dout_d  = dout_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      // any strobe outside IDLE is dropped, including the completion cycle
      ovr_d   = ovr_q | (sdram_mstrb && state_q == WAIT);
      if (state_q == IDLE && sdram_mstrb) begin
         state_d = WAIT;
         cnt_d   = 4'(LATENCY - 1);
         addr_d  = sdram_addr;
         din_d   = sdram_din;
         wr_d    = sdram_wr_rd;
         busy_d  = 1'b1;
      end
      if (state_q == WAIT) begin
         cnt_d = done ? cnt_q : cnt_q - 4'd1;
         if (done) begin
            state_d = IDLE;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            dout_d  = wr_q ? dout_q : mem[addr_q];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         wr_q    <= 1'b0;
         dout_q  <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end
   // store has no reset; a reset in the commit cycle suppresses the write
   always_ff @(posedge clk) begin
      if (!rst && done && wr_q) mem[addr_q] <= din_q;
   end
   assign sdram_dout = dout_q;
   assign sdram_ack  = ack_q;
   assign sdram_busy = busy_q;
   assign sdram_ovr  = ovr_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed plus random requests checked against a byte-map reference model.
module tb_sdram_responder;
   localparam int L = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] sdram_addr = '0;
   logic [7:0]  sdram_din = '0;
   logic        sdram_wr_rd = 1'b0;
   logic        sdram_mstrb = 1'b0;
   logic [7:0]  sdram_dout;
   logic        sdram_ack, sdram_busy, sdram_ovr;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  ref_mem [int];
   logic [7:0]  ref_dout = 8'h00;
   logic        ref_ovr = 1'b0;
   logic [15:0] written [$];

   sdram_responder #(.ADDR_W(16), .DATA_W(8), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
      .sdram_wr_rd(sdram_wr_rd), .sdram_mstrb(sdram_mstrb), .sdram_dout(sdram_dout),
      .sdram_ack(sdram_ack), .sdram_busy(sdram_busy), .sdram_ovr(sdram_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      sdram_addr  = 16'($urandom);
      sdram_din   = 8'($urandom);
      sdram_wr_rd = 1'($urandom);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ack"}, 16'(sdram_ack), 16'd0);
      chk({tag, ".busy"}, 16'(sdram_busy), 16'd0);
      chk({tag, ".dout"}, 16'(sdram_dout), 16'(ref_dout));
      chk({tag, ".ovr"}, 16'(sdram_ovr), 16'(ref_ovr));
   endtask

   // Issue one request at the current negedge; ovr_k >= 0 adds a stray strobe
   // sampled at the edge E0+ovr_k+1. Returns at the negedge of the ack cycle.
   task automatic req(input bit wr, input logic [15:0] a, input logic [7:0] d, input int ovr_k);
      sdram_mstrb = 1'b1;
      sdram_wr_rd = wr;
      sdram_addr  = a;
      sdram_din   = d;
      @(negedge clk);
      for (int k = 0; k <= L; k++) begin
         if (k == L) begin
            if (wr) begin
               ref_mem[int'(a)] = d;
               written.push_back(a);
            end else ref_dout = ref_mem[int'(a)];
         end
         chk($sformatf("busy k%0d", k), 16'(sdram_busy), 16'(k < L));
         chk($sformatf("ack k%0d", k), 16'(sdram_ack), 16'(k == L));
         chk($sformatf("dout k%0d", k), 16'(sdram_dout), 16'(ref_dout));
         chk($sformatf("ovr k%0d", k), 16'(sdram_ovr), 16'(ref_ovr));
         if (k < L) begin
            sdram_mstrb = (k == ovr_k);
            scramble();
            @(negedge clk);
            if (k == ovr_k) ref_ovr = 1'b1;
         end
      end
      sdram_mstrb = 1'b0;
   endtask

   initial begin
      repeat (2) begin
         sdram_mstrb = 1'($urandom);
         scramble();
         @(negedge clk);
      end
      rst = 1'b0;
      sdram_mstrb = 1'b0;
      @(negedge clk);
      chk_idle("reset");

      req(1'b1, 16'h1234, 8'hA5, -1);
      req(1'b0, 16'h1234, 8'h00, -1);
      @(negedge clk);
      chk_idle("read hold");

      req(1'b1, 16'h0011, 8'h5A, -1);
      req(1'b1, 16'h0010, 8'h3C, -1);
      req(1'b0, 16'h0010, 8'h00, -1);
      req(1'b0, 16'h0011, 8'h00, -1);

      req(1'b0, 16'h1234, 8'h00, 1);
      repeat (100) @(negedge clk);
      chk_idle("ovr sticky");

      for (int i = 0; i < 30; i++) begin
         bit wr = 1'($urandom);
         logic [15:0] a = wr ? 16'($urandom) : written[$urandom_range(written.size() - 1)];
         if (wr && $urandom_range(1) == 0) a = written[$urandom_range(written.size() - 1)];
         req(wr, a, 8'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(L - 1)) : -1);
         repeat ($urandom_range(2)) @(negedge clk);
      end

      req(1'b1, 16'h0040, 8'h11, -1);
      @(negedge clk);
      sdram_mstrb = 1'b1;
      sdram_wr_rd = 1'b1;
      sdram_addr  = 16'h0040;
      sdram_din   = 8'h22;
      @(negedge clk);
      sdram_mstrb = 1'b0;
      chk("abort busy", 16'(sdram_busy), 16'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ref_ovr  = 1'b0;
      ref_dout = 8'h00;
      for (int k = 0; k < L + 2; k++) begin
         chk_idle($sformatf("abort k%0d", k));
         @(negedge clk);
      end
      req(1'b0, 16'h0040, 8'h00, -1);

      req(1'b1, 16'h0000, 8'h01, -1);
      req(1'b1, 16'hFFFF, 8'hFE, -1);
      req(1'b0, 16'h0000, 8'h00, -1);
      req(1'b0, 16'hFFFF, 8'h00, -1);
      @(negedge clk);
      chk_idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
